hps_pio_in_debounce: RTL and testbench

Parametrised Avalon-MM input PIO for HPS-side push-buttons and switches. It is the successor to the plain read-only key port and adds:
- per-channel synchroniser and debouncer;
- edge-capture register with write-1-to-clear;
- per-channel interrupt mask and a level IRQ.

It sits on the lightweight HPS-to-FPGA bridge, one instance per input group (keys, switches).

---
 rtl/hps_pio_pkg.sv | 13 +
 rtl/pio_debounce_bit.sv | 48 ++++
 rtl/hps_pio_in_debounce.sv | 112 +++++++++++
 tb/tb_hps_pio_in_debounce.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hps_pio_pkg.sv
// Shared constants for the HPS input PIO: register map and edge-capture selection.
package hps_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_ANY  = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_FALL = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: multi-flop synchroniser followed by a persistence-counter debouncer.
module pio_debounce_bit #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INIT            = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  output logic o_sync,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;

  // Synchroniser shift chain; the oldest stage is the usable sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  // New level is accepted only after it has differed from stable for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= INIT;
    end else if (o_sync == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= o_sync;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

endmodule

// File: rtl/hps_pio_in_debounce.sv
// Avalon-MM input PIO with per-channel debounce, W1C edge capture and masked level IRQ.
module hps_pio_in_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  import hps_pio_pkg::*;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge_ev;
  logic [WIDTH-1:0] w_wr_bits;
  logic [WIDTH-1:0] w_ec_next;
  logic [WIDTH-1:0] w_rd_mux;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (INIT_VALUE[i])
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_in    (in_port[i]),
      .o_sync  (w_sync[i]),
      .o_stable(w_stable[i])
    );
  end

  assign w_wr_bits = WIDTH'(writedata);
  assign w_wr_mask = chipselect && write && (address == ADDR_MASK);
  assign w_wr_edge = chipselect && write && (address == ADDR_EDGE);

  // Edge event selection; keys idle high so falling is the default
  always_comb begin
    w_edge_ev = '0;
    case (EDGE_TYPE)
      EDGE_ANY:  w_edge_ev = w_stable ^ r_stable_d;
      EDGE_RISE: w_edge_ev = w_stable & ~r_stable_d;
      default:   w_edge_ev = ~w_stable & r_stable_d;
    endcase
  end

  // Set has priority over a same-cycle write-1-to-clear
  always_comb begin
    w_ec_next = r_edge_cap | w_edge_ev;
    if (w_wr_edge) begin
      w_ec_next = (r_edge_cap & ~w_wr_bits) | w_edge_ev;
    end else begin
      w_ec_next = r_edge_cap | w_edge_ev;
    end
  end

  // Read multiplexer
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = w_stable;
      ADDR_RAW:  w_rd_mux = w_sync;
      ADDR_MASK: w_rd_mux = r_mask;
      ADDR_EDGE: w_rd_mux = r_edge_cap;
      default:   w_rd_mux = '0;
    endcase
  end

  // Edge history, register file, IRQ and registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= INIT_VALUE;
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_readdata <= 32'h0;
      r_irq      <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      r_edge_cap <= w_ec_next;
      r_irq      <= |(w_ec_next & r_mask);
      if (w_wr_mask) begin
        r_mask <= w_wr_bits;
      end
      if (chipselect && read) begin
        r_readdata <= 32'(w_rd_mux);
      end else begin
        r_readdata <= 32'h0;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_hps_pio_in_debounce.sv
// Directed bench for hps_pio_in_debounce with a short debounce window (4 clocks).
module tb_hps_pio_in_debounce;
  import hps_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  hps_pio_in_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .INIT_VALUE(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Bus helpers: called at a negedge, return at the following negedge
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 00000000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL reset_data: got %h want 0000000f", d); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_edge: got %h want 00000000", d); end
    bus_read(ADDR_MASK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 00000000", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after: got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port = 4'hD;
    repeat (2) @(negedge clk);
    bus_read(ADDR_RAW, d);
    checks++; if (d !== 32'h0000000D) begin errors++; $display("FAIL glitch_raw: got %h want 0000000d", d); end
    in_port = 4'hF;
    repeat (8) @(negedge clk);
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL glitch_data: got %h want 0000000f", d); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h want 00000000", d); end
  endtask

  task automatic test_hold();
    logic [31:0] d;
    in_port = 4'hD;
    repeat (4) @(negedge clk);
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL hold_early: got %h want 0000000f", d); end
    @(negedge clk);
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0000000D) begin errors++; $display("FAIL hold_data: got %h want 0000000d", d); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h00000002) begin errors++; $display("FAIL hold_edge: got %h want 00000002", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hold_irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(ADDR_MASK, 32'h2);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask: got %b want 1", irq); end
    bus_write(ADDR_EDGE, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", irq); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_edge: got %h want 00000000", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    in_port = 4'hC;
    repeat (6) @(negedge clk);
    bus_write(ADDR_EDGE, 32'h1);
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL set_wins: got %h want 00000001", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL set_wins_irq: got %b want 0", irq); end
    // Read and W1C in the same cycle: read sees the pre-write value
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = ADDR_EDGE; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
    checks++; if (readdata !== 32'h00000001) begin errors++; $display("FAIL rw_same_cycle: got %h want 00000001", readdata); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_cleared: got %h want 00000000", d); end
  endtask

  task automatic test_rise_ignored();
    logic [31:0] d;
    in_port = 4'hF;
    repeat (10) @(negedge clk);
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL rise_data: got %h want 0000000f", d); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rise_edge: got %h want 00000000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(ADDR_MASK, 32'hF);
    in_port = 4'hE;
    repeat (8) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    in_port = 4'hA;
    repeat (3) @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = ADDR_DATA;
    @(negedge clk);
    checks++; if (readdata !== 32'h0000000E) begin errors++; $display("FAIL mid_data: got %h want 0000000e", readdata); end
    #2;
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; read = 1'b0;
    #1;
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL async_readdata: got %h want 00000000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b want 0", irq); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL post_reset_data: got %h want 0000000f", d); end
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_edge: got %h want 00000000", d); end
    repeat (10) @(negedge clk);
    bus_read(ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL settle_edge: got %h want 00000000", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL settle_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_irq();
    test_set_wins();
    test_rise_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
